// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks R0..R(2**ADDR_WIDTH-1) through the two regfile read
// ports, one even/odd pair per cycle, and streams every register out as one
// valid/ready beat via a small capture FIFO.
// Optional: define REGDUMP_CHECKSUM_EN to append one beat carrying the XOR of
// all dumped values (out_addr=0); out_last then moves to that beat.
module regfile_dump_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ra1,
  output logic [ADDR_WIDTH-1:0] ra2,
  input  logic [DATA_WIDTH-1:0] rd1,
  input  logic [DATA_WIDTH-1:0] rd2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned PairW = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                state_q, state_d;
  logic [PairW-1:0]      pair_q, pair_d;
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [PtrW-1:0]       wptr_nxt;
  logic [CntW-1:0]       count_q, count_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];

  logic fifo_empty;
  logic issue;
  logic pop;
  logic accept;
  logic csum_beat;

  assign fifo_empty = (count_q == '0);
  // Free-space check uses the registered count only; a same-cycle pop is not credited.
  assign issue      = (state_q == StRead) && (count_q <= CntW'(FIFO_DEPTH - 2));
  assign pop        = !fifo_empty && out_ready;
  assign accept     = out_valid && out_ready;
  assign wptr_nxt   = wptr_q + PtrW'(1);

  assign ra1  = (state_q == StRead) ? {pair_q, 1'b0} : '0;
  assign ra2  = (state_q == StRead) ? {pair_q, 1'b1} : '0;
  assign busy = (state_q != StIdle);
  assign done = done_q;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit ChecksumEn = 1'b1;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  // The checksum beat is offered once every captured register has drained.
  assign csum_beat = (state_q == StDrain) && fifo_empty;

  // Running XOR of all captured values, cleared when a dump starts.
  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle && start) begin
      csum_d = '0;
    end else if (issue) begin
      csum_d = csum_q ^ rd1 ^ rd2;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`else
  localparam bit ChecksumEn = 1'b0;
  assign csum_beat = 1'b0;
`endif

  // Output stream: FIFO head, or the checksum beat when enabled; zero when idle.
  always_comb begin
    out_valid = !fifo_empty;
    out_addr  = '0;
    out_data  = '0;
    out_last  = 1'b0;
    if (!fifo_empty) begin
      out_addr = mem_addr[rptr_q];
      out_data = mem_data[rptr_q];
      out_last = !ChecksumEn && (&mem_addr[rptr_q]);
    end
`ifdef REGDUMP_CHECKSUM_EN
    if (csum_beat) begin
      out_valid = 1'b1;
      out_data  = csum_q;
      out_last  = 1'b1;
    end
`endif
  end

  // Next-state logic for the dump sequencer and FIFO occupancy.
  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    done_d  = 1'b0;
    count_d = count_q;
    if (issue) begin
      count_d = count_d + CntW'(2);
    end
    if (pop) begin
      count_d = count_d - CntW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          pair_d  = '0;
        end
      end
      StRead: begin
        if (issue) begin
          pair_d = pair_q + PairW'(1);
          if (&pair_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (accept && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, pointers and done pulse; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pair_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      count_q <= count_d;
      done_q  <= done_d;
      if (issue) begin
        wptr_q <= wptr_q + PtrW'(2);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

  // Capture storage: the even register lands first, the odd one right behind it.
  always_ff @(posedge clk) begin
    if (issue) begin
      mem_addr[wptr_q]   <= ra1;
      mem_data[wptr_q]   <= rd1;
      mem_addr[wptr_nxt] <= ra2;
      mem_data[wptr_nxt] <= rd2;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: stimulus pushes the expected beats
// of each dump, an independent monitor pops and compares on every handshake.
module tb_regfile_dump_reader;

  localparam int Budget = 2000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;

  logic [31:0] regs [16];

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t sb [$];
  beat_t mon_e;

  int n_cmp;
  int n_err;
  int done_cnt;
  int lat;

  bit          stall_prev;
  logic [3:0]  s_addr;
  logic [31:0] s_data;
  logic        s_last;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  regfile_dump_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // Behavioural regfile: combinational read ports.
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a dump is every register in address order, plus optional XOR beat.
  task automatic push_expected();
    beat_t b;
    logic [31:0] x;
    x = '0;
    for (int a = 0; a < 16; a++) begin
      b.a = 4'(a);
      b.d = regs[a];
      b.l = !ChkEn && (a == 15);
      x   = x ^ regs[a];
      sb.push_back(b);
    end
    if (ChkEn) begin
      b.a = 4'd0;
      b.d = x;
      b.l = 1'b1;
      sb.push_back(b);
    end
  endtask

  // Monitor: compares each accepted beat and checks hold-under-backpressure.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk(out_valid, "hold_valid", longint'(out_valid), 1);
        chk(out_addr == s_addr && out_data == s_data && out_last == s_last, "hold_beat",
            longint'({out_last, out_addr, out_data}), longint'({s_last, s_addr, s_data}));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_beat", longint'(out_addr), 0);
        end else begin
          mon_e = sb.pop_front();
          chk(out_addr == mon_e.a, "beat_addr", longint'(out_addr), longint'(mon_e.a));
          chk(out_data == mon_e.d, "beat_data", longint'(out_data), longint'(mon_e.d));
          chk(out_last == mon_e.l, "beat_last", longint'(out_last), longint'(mon_e.l));
        end
      end
      stall_prev = out_valid && !out_ready;
      s_addr     = out_addr;
      s_data     = out_data;
      s_last     = out_last;
      if (done) done_cnt++;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk(busy == 1'b0 && done == 1'b0 && out_valid == 1'b0 && out_last == 1'b0,
        {tag, "_flags"}, longint'({busy, done, out_valid, out_last}), 0);
    chk(ra1 == 4'd0 && ra2 == 4'd0, {tag, "_ra"}, longint'({ra1, ra2}), 0);
    chk(out_addr == 4'd0 && out_data == 32'd0, {tag, "_out"}, longint'({out_addr, out_data}), 0);
  endtask

  // mode: 0 ready=1, 1 toggle 1/0, 2 random, 3 held low through cycle 10.
  task automatic run_dump(input int mode, input int restart_at, input int reset_at,
                          output int latency);
    int  d0;
    bit  got;
    d0      = done_cnt;
    got     = 1'b0;
    latency = -1;
    push_expected();
    for (int i = 0; i < Budget; i++) begin
      @(posedge clk);
      #1;
      start = (i == 0) || (i == restart_at);
      reset = (i == reset_at);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (i % 2 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (i > 10);
      endcase
      @(negedge clk);
      if (mode == 3 && i == 10) begin
        chk(ra1 == 4'd4 && ra2 == 4'd5, "stall_ra", longint'({ra1, ra2}), 'h45);
        chk(out_valid == 1'b1 && out_addr == 4'd0, "stall_head",
            longint'({out_valid, out_addr}), 'h10);
        chk(busy == 1'b1, "stall_busy", longint'(busy), 1);
      end
      if (reset_at >= 0 && i == reset_at + 1) begin
        check_idle_outputs("after_reset");
        sb.delete();
        got = 1'b1;
        break;
      end
      if (done) begin
        latency = i;
        got     = 1'b1;
        break;
      end
    end
    chk(got, "dump_timeout", longint'(got), 1);
    start = 1'b0;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(done_cnt - d0 == ((reset_at >= 0) ? 0 : 1), "done_count",
        longint'(done_cnt - d0), (reset_at >= 0) ? 0 : 1);
    chk(sb.size() == 0, "beats_left", longint'(sb.size()), 0);
    chk(busy == 1'b0, "idle_after", longint'(busy), 0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    done_cnt   = 0;
    stall_prev = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < 15; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[15] = 32'h0000_0108;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Directed data, full throughput: done lands 18 cycles after start.
    run_dump(0, -1, -1, lat);
    chk(lat == (ChkEn ? 19 : 18), "latency", longint'(lat), ChkEn ? 19 : 18);

    // Backpressure for 10 cycles after start.
    run_dump(3, -1, -1, lat);

    // Alternating ready.
    run_dump(1, -1, -1, lat);

    // Start pulsed again around beat 5 must be ignored.
    run_dump(0, 7, -1, lat);

    // Reset during beat 7, then a fresh dump from R0.
    run_dump(0, -1, 9, lat);
    run_dump(0, -1, -1, lat);

    // Random data and random backpressure.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      run_dump(2, -1, -1, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
